// File: rtl/wb_write_sequencer_pkg.sv
// Shared widths, the write-slot payload type and the register decode helper
// used by the write-port sequencer and its slot FIFO.
package wb_write_sequencer_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned QDEPTH_DEF = 4;

  localparam logic [ADDR_W-1:0] XZR_ADDR = ADDR_W'(31);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_slot_t;

  function automatic logic [REG_NUM-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    reg_onehot = REG_NUM'(1) << a;
  endfunction

endpackage

// File: rtl/wb_write_sequencer_slot_fifo.sv
// Write-slot FIFO: up to two pushes and one pop per cycle, with per-entry
// valid/address taps so the parent can build the pending-write mask.
module wb_slot_fifo
  import wb_write_sequencer_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(QDEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     push_n,
  input  wb_slot_t                       push_a,
  input  wb_slot_t                       push_b,
  input  logic                           pop,
  output wb_slot_t                       head,
  output logic                           empty,
  output logic [CNT_W-1:0]               count,
  output logic [QDEPTH-1:0]              ent_valid,
  output logic [QDEPTH-1:0][ADDR_W-1:0]  ent_addr
);

  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d, wr_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] off;
  wb_slot_t         mem_q [QDEPTH];

  always_comb begin
    wr_nxt  = wr_q + PTR_W'(1);
    wr_d    = wr_q + PTR_W'(push_n);
    rd_d    = rd_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem_q[wr_q]   <= push_a;
    if (push_n == 2'd2) mem_q[wr_nxt] <= push_b;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    off       = '0;
    ent_valid = '0;
    ent_addr  = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      off          = PTR_W'(i) - rd_q;
      ent_valid[i] = {1'b0, off} < count_q;
      ent_addr[i]  = mem_q[i].addr;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/wb_write_sequencer.sv
// Register-file write-port sequencer: filters/dedups MEM/WB write slots, queues
// them and retires one write per cycle in program order, tracking pending dests.
module wb_write_sequencer
  import wb_write_sequencer_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEF,
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_we0,
  input  logic [ADDR_W-1:0]  in_waddr0,
  input  logic [DATA_W-1:0]  in_wdata0,
  input  logic               in_we1,
  input  logic [ADDR_W-1:0]  in_waddr1,
  input  logic [DATA_W-1:0]  in_wdata1,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic [REG_NUM-1:0] pending_mask,
  output logic               idle
);

  logic                          keep0, keep1, accept;
  logic [1:0]                    push_n;
  wb_slot_t                      push_a, push_b, head;
  logic                          fifo_empty;
  logic [CNT_W-1:0]              count;
  logic [QDEPTH-1:0]             ent_valid;
  logic [QDEPTH-1:0][ADDR_W-1:0] ent_addr;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Admission leaves room for a full pair even if nothing pops this cycle.
  assign in_ready = (count <= CNT_W'(QDEPTH - 2));

  // Slot filtering: XZR is never written, and slot 1 supersedes a same-dest slot 0.
  always_comb begin
    keep1  = in_we1 && (in_waddr1 != XZR_ADDR);
    keep0  = in_we0 && (in_waddr0 != XZR_ADDR) && !(keep1 && (in_waddr0 == in_waddr1));
    accept = in_valid && in_ready;
    push_a = '{addr: in_waddr0, data: in_wdata0};
    push_b = '{addr: in_waddr1, data: in_wdata1};
    push_n = 2'd0;
    if (accept) begin
      if (keep0 && keep1) begin
        push_n = 2'd2;
      end else if (keep0) begin
        push_n = 2'd1;
      end else if (keep1) begin
        push_n = 2'd1;
        push_a = push_b;
      end
    end
  end

  wb_slot_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_n    (push_n),
    .push_a    (push_a),
    .push_b    (push_b),
    .pop       (!fifo_empty),
    .head      (head),
    .empty     (fifo_empty),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  always_comb begin
    we_d    = !fifo_empty;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (!fifo_empty) begin
      waddr_d = head.addr;
      wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (ent_valid[i]) pending_mask = pending_mask | reg_onehot(ent_addr[i]);
    end
    if (we_q) pending_mask = pending_mask | reg_onehot(waddr_q);
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign idle  = fifo_empty && !we_q;

endmodule
